// File: rtl/adc_sample_capture.sv
// adc_sample_capture
//   Digital-side consumer of a SAR ADC. Divides the core clock to make the
//   ADC conversion clock, captures one sample per conversion on the falling
//   edge of that clock, box-car averages 2^dec_eff samples and queues the
//   averages in a small FIFO drained through a valid/ready port.
//
// Ports
//   clock, reset        core clock, synchronous active-high reset
//   enable              run conversions (low = idle)
//   clk_div             adc_clock half-period minus one, in core cycles
//   dec_log2            decimation exponent, clamped to DEC_MAX
//   adc_clock           conversion clock to the analog macro
//   adc_data            ADC result, stable around adc_clock falling edges
//   out_valid/ready     FIFO head handshake, out_bits = head entry
//   fifo_count          FIFO occupancy
//   overflow            sticky drop flag, cleared by clear_overflow
module adc_sample_capture #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8,
  parameter int DEC_MAX    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [2:0]                    dec_log2,
  output logic                          adc_clock,
  input  logic [DATA_W-1:0]             adc_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_bits,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = DATA_W + DEC_MAX;
  localparam int CNT_W = DEC_MAX + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_adc_clk;
  logic                  r_smp_vld;
  logic [DATA_W-1:0]     r_sample;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_smp_cnt;
  logic [2:0]            r_dec_eff;
  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [AW:0]           r_count;
  logic [DATA_W-1:0]     r_last;
  logic                  r_ovf;

  logic                  w_run, w_tc, w_strobe;
  logic [2:0]            w_dec_in, w_dec_cur;
  logic [ACC_W-1:0]      w_acc_sum;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_done, w_push, w_pop, w_full, w_wr;
  logic [DATA_W-1:0]     w_result;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run = (r_state == S_RUN);

  // ---------------- clock divider ----------------
  // Equality terminal count: if clk_div drops below the running count the
  // counter simply wraps through 2^DIV_W-1, so no short adc_clock phase.
  assign w_tc     = (r_div_cnt == clk_div);
  assign w_strobe = w_run && enable && w_tc && r_adc_clk;

  always_ff @(posedge clock) begin
    if (reset || !w_run || !enable) begin
      r_div_cnt <= '0;
      r_adc_clk <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign adc_clock = r_adc_clk;

  // Sample register: adc_data taken at the edge that drives adc_clock low.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_smp_vld <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_smp_vld <= w_strobe;
      if (w_strobe) r_sample <= adc_data;
    end
  end

  // ---------------- decimating accumulator ----------------
  assign w_dec_in  = (int'(dec_log2) > DEC_MAX) ? 3'(DEC_MAX) : dec_log2;
  // First sample of a block uses the live setting; the rest use the latch.
  assign w_dec_cur = (r_smp_cnt == '0) ? w_dec_in : r_dec_eff;
  assign w_acc_sum = r_acc + ACC_W'(r_sample);
  assign w_cnt_nxt = r_smp_cnt + CNT_W'(1);
  assign w_done    = (w_cnt_nxt == (CNT_W'(1) << w_dec_cur));
  assign w_result  = DATA_W'(w_acc_sum >> w_dec_cur);
  assign w_push    = r_smp_vld && w_run && w_done;

  always_ff @(posedge clock) begin
    if (reset || !w_run) begin
      r_acc     <= '0;
      r_smp_cnt <= '0;
      r_dec_eff <= '0;
    end else if (r_smp_vld) begin
      if (r_smp_cnt == '0) r_dec_eff <= w_dec_in;
      if (w_done) begin
        r_acc     <= '0;
        r_smp_cnt <= '0;
      end else begin
        r_acc     <= w_acc_sum;
        r_smp_cnt <= w_cnt_nxt;
      end
    end
  end

  // ---------------- result FIFO ----------------
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Set has priority over clear.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (clear_overflow)        r_ovf <= 1'b0;
    end
  end

  assign out_valid  = (r_count != '0);
  // Empty FIFO keeps showing the last popped value.
  assign out_bits   = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: reset flush, divider timing,
// decimation, overflow, full-FIFO push+pop, and enable drop mid-block.
module tb_adc_sample_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] clk_div = 8'd1;
  logic [2:0] dec_log2 = 3'd0;
  logic       adc_clock;
  logic [7:0] adc_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_bits;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  adc_sample_capture #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_W(8), .DEC_MAX(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clk_div(clk_div),
    .dec_log2(dec_log2), .adc_clock(adc_clock), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge of the cycle right after a capture cycle (C+1).
  task automatic wait_fall();
    logic prev;
    bit   found;
    prev  = adc_clock;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (prev === 1'b1 && adc_clock === 1'b0) found = 1'b1;
      prev = adc_clock;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_fall timeout observed=no-fall expected=fall");
    end
  endtask

  task automatic feed(input logic [7:0] v);
    adc_data = v;
    wait_fall();
  endtask

  initial begin
    int lo, hi;
    // ---- reset state ----
    cycles(3);
    reset = 1'b0;
    chk("rst_count",  32'(fifo_count), 32'd0);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_adcclk", 32'(adc_clock),  32'd0);
    chk("rst_ovf",    32'(overflow),   32'd0);
    chk("rst_bits",   32'(out_bits),   32'd0);

    // ---- 1: reset while running with 3 queued entries ----
    enable = 1'b1;
    feed(8'hA1); feed(8'hA2); feed(8'hA3);
    @(negedge clock);
    chk("t1_count3", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    chk("t1_count",  32'(fifo_count), 32'd0);
    chk("t1_valid",  32'(out_valid),  32'd0);
    chk("t1_adcclk", 32'(adc_clock),  32'd0);
    chk("t1_ovf",    32'(overflow),   32'd0);
    chk("t1_bits",   32'(out_bits),   32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clock);

    // ---- 2: clk_div=1, dec=0, latency exactly 2 cycles ----
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      feed(8'h10 + 8'(k));
      chk("t2_c1_valid", 32'(out_valid), 32'd0);
      @(negedge clock);
      chk("t2_c2_valid", 32'(out_valid), 32'd1);
      chk("t2_c2_bits",  32'(out_bits),  32'h10 + 32'(k));
      @(negedge clock);
      chk("t2_c3_valid", 32'(out_valid), 32'd0);
    end
    feed(8'h13);
    lo = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (adc_clock) break;
      lo++;
    end
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!adc_clock) break;
      hi++;
    end
    chk("t2_low_cycles",  32'(lo), 32'd2);
    chk("t2_high_cycles", 32'(hi), 32'd2);
    cycles(2);

    // ---- 3: decimation ----
    dec_log2 = 3'd2;
    feed(8'd10); feed(8'd11); feed(8'd12); feed(8'd13);
    chk("t3_dec2_pending", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("t3_dec2_valid", 32'(out_valid), 32'd1);
    chk("t3_dec2_bits",  32'(out_bits),  32'd11);
    dec_log2 = 3'd4;
    for (int i = 0; i < 16; i++) feed(8'd255);
    @(negedge clock);
    chk("t3_dec4_valid", 32'(out_valid), 32'd1);
    chk("t3_dec4_bits",  32'(out_bits),  32'd255);
    dec_log2 = 3'd7;
    for (int i = 0; i < 16; i++) feed(8'(i));
    @(negedge clock);
    chk("t3_dec7_valid", 32'(out_valid), 32'd1);
    chk("t3_dec7_bits",  32'(out_bits),  32'd7);
    @(negedge clock);

    // ---- 4: overflow with 9 samples into an 8-deep FIFO ----
    out_ready = 1'b0;
    dec_log2  = 3'd0;
    for (int i = 0; i < 8; i++) feed(8'h20 + 8'(i));
    @(negedge clock);
    chk("t4_full_count", 32'(fifo_count), 32'd8);
    chk("t4_full_ovf",   32'(overflow),   32'd0);
    feed(8'h28);
    @(negedge clock);
    chk("t4_drop_count", 32'(fifo_count), 32'd8);
    chk("t4_drop_ovf",   32'(overflow),   32'd1);
    chk("t4_drop_bits",  32'(out_bits),   32'h20);
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    chk("t4_clear_ovf", 32'(overflow), 32'd0);
    enable = 1'b0;
    cycles(3);
    chk("t4_idle_count", 32'(fifo_count), 32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_valid", 32'(out_valid), 32'd1);
      chk("t4_drain_bits",  32'(out_bits),  32'h20 + 32'(i));
      @(negedge clock);
    end
    chk("t4_empty_valid", 32'(out_valid), 32'd0);
    chk("t4_hold_bits",   32'(out_bits),  32'h27);
    out_ready = 1'b0;

    // ---- 5: full FIFO, push and pop in the same cycle ----
    enable = 1'b1;
    for (int i = 0; i < 8; i++) feed(8'h30 + 8'(i));
    @(negedge clock);
    chk("t5_full_count", 32'(fifo_count), 32'd8);
    feed(8'h38);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    enable    = 1'b0;
    chk("t5_pp_count", 32'(fifo_count), 32'd8);
    chk("t5_pp_ovf",   32'(overflow),   32'd0);
    chk("t5_pp_bits",  32'(out_bits),   32'h31);
    cycles(2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain_bits", 32'(out_bits), 32'h31 + 32'(i));
      @(negedge clock);
    end
    chk("t5_empty_valid", 32'(out_valid), 32'd0);

    // ---- 6: enable drop mid-block, then fresh block ----
    dec_log2 = 3'd2;
    enable   = 1'b1;
    feed(8'd100); feed(8'd100);
    cycles(2);
    chk("t6_adcclk_high", 32'(adc_clock), 32'd1);
    enable = 1'b0;
    @(negedge clock);
    chk("t6_adcclk_forced", 32'(adc_clock), 32'd0);
    cycles(4);
    chk("t6_no_push_valid", 32'(out_valid),  32'd0);
    chk("t6_no_push_count", 32'(fifo_count), 32'd0);
    enable = 1'b1;
    feed(8'd4); feed(8'd4);
    dec_log2 = 3'd0;
    feed(8'd8); feed(8'd8);
    chk("t6_pending", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_bits",  32'(out_bits),  32'd6);
    enable = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
